// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory through a req/ready
// handshake and holds the fetched word for decode until the instruction retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_nextPC,
    input  logic        i_pcsrc,
    input  logic        i_ack,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_req,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    output logic        o_misaligned,
    output logic [31:0] o_icount
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4    = pc + 32'd4;
    assign o_imem_addr = pc;

    // o_imem_req is a flop so it stays low through reset and rises on the first edge after.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= FETCH;
            pc           <= {RESET_PC[31:2], 2'b00};
            o_imem_req   <= 1'b0;
            o_instr      <= 32'd0;
            o_pc         <= 32'd0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_icount     <= 32'd0;
        end else begin
            o_misaligned <= 1'b0;
            case (state)
                FETCH: begin
                    if (o_imem_req && i_imem_ready) begin
                        o_instr    <= i_imem_data;
                        o_pc       <= pc_plus4;
                        o_valid    <= 1'b1;
                        o_imem_req <= 1'b0;
                        state      <= HOLD;
                    end else begin
                        o_imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_ack) begin
                        o_icount   <= o_icount + 32'd1;
                        o_valid    <= 1'b0;
                        o_imem_req <= 1'b1;
                        state      <= FETCH;
                        if (!i_pcsrc) begin
                            pc <= pc_plus4;
                        end else if (i_nextPC[1:0] == 2'b00) begin
                            pc <= {i_nextPC[31:2], 2'b00};
                        end else begin
                            // Misaligned taken target traps to the exception vector.
                            pc           <= {EXC_VECTOR[31:2], 2'b00};
                            o_misaligned <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared each cycle against a transaction-level model of the fetch/retire rules.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pcsrc;
    logic        ack;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid;
    logic        misaligned;
    logic [31:0] icount;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: what the instruction stream should look like.
    logic [31:0] m_pc, m_instr, m_opc, m_cnt;
    logic        m_have, m_req, m_mis;

    fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_nextPC(next_pc),
        .i_pcsrc(pcsrc),
        .i_ack(ack),
        .o_imem_addr(imem_addr),
        .o_imem_req(imem_req),
        .i_imem_ready(imem_ready),
        .i_imem_data(imem_data),
        .o_instr(instr),
        .o_pc(pc_out),
        .o_valid(valid),
        .o_misaligned(misaligned),
        .o_icount(icount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_opc = 0; m_cnt = 0;
        m_have = 0; m_req = 0; m_mis = 0;
    endtask

    task automatic check_all();
        check("addr", imem_addr, m_pc);
        check("req", {31'd0, imem_req}, {31'd0, m_req});
        check("valid", {31'd0, valid}, {31'd0, m_have});
        check("instr", instr, m_instr);
        check("pc", pc_out, m_opc);
        check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        check("icount", icount, m_cnt);
    endtask

    // One clock: the model consumes the inputs present at the edge, then outputs are compared.
    task automatic step();
        @(posedge clk);
        m_mis = 0;
        if (!m_have) begin
            if (m_req && imem_ready) begin
                m_instr = imem_data;
                m_opc   = m_pc + 4;
                m_have  = 1;
            end
        end else if (ack) begin
            m_cnt  = m_cnt + 1;
            m_have = 0;
            if (!pcsrc)                   m_pc = m_pc + 4;
            else if (next_pc % 4 == 0)    m_pc = next_pc;
            else begin                    m_pc = EXC_VECTOR; m_mis = 1; end
        end
        m_req = !m_have;
        #1;
        check_all();
    endtask

    // Wait cycles with ack/pcsrc noise, then one ready beat.
    task automatic fetch(input int waits, input logic [31:0] data);
        imem_ready = 0;
        for (int i = 0; i < waits; i++) begin
            ack = i[0]; pcsrc = ~i[0]; next_pc = 32'h0000_0100;
            step();
        end
        ack = 0; pcsrc = 0;
        imem_ready = 1; imem_data = data;
        step();
        imem_ready = 0;
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        ack = 1; pcsrc = src; next_pc = tgt;
        step();
        ack = 0; pcsrc = 0;
    endtask

    initial begin
        rst = 1; next_pc = 0; pcsrc = 0; ack = 0; imem_ready = 0; imem_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();

        // Release reset; req rises on the first edge, then first fetch.
        rst = 0;
        step();
        fetch(0, 32'h2008_0005);
        check("first_instr", instr, 32'h2008_0005);
        check("first_pc", pc_out, 32'h0000_0004);

        // Sequential retirements with 0/2/5 wait cycles.
        retire(0, 0); fetch(0, 32'h1111_0001);
        retire(0, 0); fetch(2, 32'h1111_0002);
        retire(0, 0); fetch(5, 32'h1111_0003);
        check("seq_addr", imem_addr, 32'h0000_000C);
        check("seq_icount", icount, 32'd3);

        // Branch taken, then pcsrc toggled in HOLD without ack.
        retire(1, 32'h0000_0040);
        check("branch_addr", imem_addr, 32'h0000_0040);
        fetch(1, 32'h2222_0000);
        check("branch_pc", pc_out, 32'h0000_0044);
        pcsrc = 1; next_pc = 32'h0000_0300; step();
        pcsrc = 0; step();

        // Misaligned target: single pulse, PC to exception vector.
        retire(1, 32'h0000_0042);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("mis_addr", imem_addr, 32'h0000_0080);
        step();
        check("mis_clear", {31'd0, misaligned}, 32'd0);

        // PC wrap from the top of memory.
        fetch(0, 32'h3333_0000);
        retire(1, 32'hFFFF_FFFC);
        fetch(0, 32'h4444_0000);
        check("wrap_opc", pc_out, 32'h0000_0000);
        retire(0, 0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset in the middle of a fetch wait at PC 0x10.
        fetch(0, 32'h5555_0000);
        retire(1, 32'h0000_0010);
        imem_ready = 0; step();
        #2 rst = 1; imem_ready = 1; imem_data = 32'hDEAD_BEEF;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1; check_all();
        imem_ready = 0; rst = 0;
        step();
        check("post_rst_addr", imem_addr, RESET_PC);
        check("post_rst_icount", icount, 32'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            imem_ready = ($urandom_range(0, 2) == 0);
            imem_data  = $urandom;
            ack        = $urandom_range(0, 1);
            pcsrc      = $urandom_range(0, 1);
            next_pc    = $urandom;
            if ($urandom_range(0, 1) == 1) next_pc[1:0] = 2'b00;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
